// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM encoding, address map and widths for the SRAM controller
package sram_ctrl_pkg;
   localparam int DATA_W = 32;
   localparam int SRAM_AW = 17;
   localparam int CNT_W = 3;
   localparam int SRAM_WAIT = 5;
   localparam logic [31:0] SRAM_BASE = 32'd1024;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: MEM-stage request/response bus between the pipeline and the SRAM controller
interface sram_ctrl_if;
   import sram_ctrl_pkg::*;
   logic MEMwrite;
   logic MEMread;
   logic [31:0] address;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] MEM_Result;
   logic ready;
   modport master (output MEMwrite, MEMread, address, data, input MEM_Result, ready);
   modport slave (input MEMwrite, MEMread, address, data, output MEM_Result, ready);
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: stretches a held MEM-stage read/write into a fixed-length async SRAM access
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = SRAM_WAIT,
   parameter logic [31:0] BASE_ADDR = SRAM_BASE,
   parameter int ADDR_W = SRAM_AW
) (
   input logic clk,
   input logic rst,
   sram_ctrl_if.slave bus,
   inout wire [DATA_W-1:0] sram_dq,
   output logic [ADDR_W-1:0] sram_addr,
   output logic sram_wb_en,
   output logic SRAM_UB_N,
   output logic SRAM_LB_N,
   output logic SRAM_CE_N,
   output logic SRAM_OE_N
);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [DATA_W-1:0] res;
   logic wr;
   logic req;
   logic last;
   assign req = bus.MEMread | bus.MEMwrite;
   assign last = cnt == CNT_W'(WAIT_CYCLES - 1);
   assign sram_addr = ADDR_W'((bus.address - BASE_ADDR) >> 2);
   assign sram_dq = sram_wb_en ? {DATA_W{1'bz}} : bus.data;
   assign bus.MEM_Result = res;
   assign {SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N} = 4'b0000;
   // access type is latched on entry so a dropped request still finishes as the same kind
   always_ff @(posedge clk)
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         wr <= 1'b0;
         res <= '0;
      end else begin
         state <= state_n;
         cnt <= state == ACCESS ? cnt + CNT_W'(1) : '0;
         if (state == IDLE && req) wr <= bus.MEMwrite;
         if (state == ACCESS && last && !wr) res <= sram_dq;
      end
   always_comb begin
      state_n = IDLE;
      if (state == IDLE) state_n = req ? ACCESS : IDLE;
      else if (state == ACCESS) state_n = last ? DONE : ACCESS;
      bus.ready = state == IDLE ? ~req : state == DONE;
      sram_wb_en = !(state == ACCESS && wr);
   end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: per-cycle timeline model of the controller plus a behavioural async SRAM
module tb_sram_ctrl;
   import sram_ctrl_pkg::*;
   localparam int W = 5;
   localparam int N = 256;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   sram_ctrl_if bus();
   wire [31:0] sram_dq;
   logic [16:0] sram_addr;
   logic sram_wb_en, ub_n, lb_n, ce_n, oe_n;
   sram_ctrl dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_wb_en(sram_wb_en),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
   );
   logic [31:0] mem [0:(1<<17)-1];
   assign sram_dq = sram_wb_en ? mem[sram_addr] : 32'bz;
   always @(posedge clk) if (!sram_wb_en) mem[sram_addr] <= sram_dq;
   // expected outputs indexed by absolute cycle number
   logic exp_ready [N];
   logic exp_wb [N];
   logic exp_av [N];
   logic [16:0] exp_addr [N];
   logic [31:0] exp_dq [N];
   logic [31:0] exp_res [N];
   logic [31:0] model_mem [int];
   int vecs = 0;
   int errs = 0;
   int cyc = 0;
   int done_cyc = -1;
   logic chk_on = 1'b0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
      end
   endtask
   always @(negedge clk) if (chk_on && cyc < N) begin
      chk("ready", 32'(bus.ready), 32'(exp_ready[cyc]));
      chk("wb_en", 32'(sram_wb_en), 32'(exp_wb[cyc]));
      chk("result", bus.MEM_Result, exp_res[cyc]);
      if (exp_av[cyc]) chk("addr", 32'(sram_addr), 32'(exp_addr[cyc]));
      if (!exp_wb[cyc]) chk("wdata", sram_dq, exp_dq[cyc]);
      if (bus.ready && (bus.MEMread || bus.MEMwrite)) done_cyc = cyc;
   end
   // call at the start of a cycle; returns at the start of the cycle after DONE
   task automatic xact(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      int c = cyc;
      logic [16:0] wa = 17'((a - 32'd1024) >> 2);
      for (int k = 0; k <= W + 1; k++) begin
         exp_ready[c+k] = k == W + 1;
         exp_av[c+k] = 1'b1;
         exp_addr[c+k] = wa;
         exp_wb[c+k] = !(w && k >= 1 && k <= W);
         exp_dq[c+k] = d;
      end
      if (w) model_mem[int'(wa)] = d;
      else for (int i = c + W + 1; i < N; i++) exp_res[i] = model_mem[int'(wa)];
      bus.MEMwrite = w;
      bus.MEMread = r;
      bus.address = a;
      bus.data = d;
      repeat (W + 2) @(posedge clk);
      #1;
      bus.MEMwrite = 1'b0;
      bus.MEMread = 1'b0;
   endtask
   initial begin
      int c, t0;
      for (int i = 0; i < N; i++) begin
         exp_ready[i] = 1'b1;
         exp_wb[i] = 1'b1;
         exp_av[i] = 1'b0;
         exp_addr[i] = '0;
         exp_dq[i] = '0;
         exp_res[i] = '0;
      end
      bus.MEMwrite = 1'b0;
      bus.MEMread = 1'b0;
      bus.address = 32'd1024;
      bus.data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1'b1;
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_wb_en", 32'(sram_wb_en), 32'd1);
      chk("rst_result", bus.MEM_Result, 32'h0);
      chk("tie_offs", 32'({ub_n, lb_n, ce_n, oe_n}), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      xact(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
      chk("wr_addr0", 32'(sram_addr), 32'd0);
      chk("wr_mem0", mem[0], 32'hDEADBEEF);
      xact(1'b1, 1'b0, 32'd1032, 32'h12345678);
      @(posedge clk); #1;
      xact(1'b0, 1'b1, 32'd1032, 32'h0);
      chk("rb_addr2", 32'(sram_addr), 32'd2);
      chk("rb_result", bus.MEM_Result, 32'h12345678);
      @(posedge clk); #1;
      t0 = cyc;
      xact(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D);
      xact(1'b0, 1'b1, 32'd1028, 32'h0);
      chk("b2b_len", 32'(done_cyc - t0 + 1), 32'd14);
      chk("b2b_result", bus.MEM_Result, 32'hCAFEF00D);
      xact(1'b1, 1'b0, 32'd1024 + 4 * 300 + 3, 32'h0BADF00D);
      chk("map300", 32'(sram_addr), 32'd300);
      chk("map_mem", mem[300], 32'h0BADF00D);
      xact(1'b0, 1'b1, 32'd1024 + 4 * 300, 32'h0);
      xact(1'b1, 1'b1, 32'd1036, 32'h55AA55AA);
      chk("prio_hold", bus.MEM_Result, 32'h0BADF00D);
      xact(1'b0, 1'b1, 32'd1036, 32'h0);
      xact(1'b1, 1'b0, 32'd1020, 32'h13579BDF);
      chk("wrap_addr", 32'(sram_addr), 32'h1FFFF);
      @(posedge clk); #1;
      c = cyc;
      for (int k = 0; k <= 3; k++) begin
         exp_ready[c+k] = 1'b0;
         exp_av[c+k] = 1'b1;
         exp_addr[c+k] = 17'd2;
      end
      for (int i = c + 4; i < N; i++) exp_res[i] = 32'h0;
      bus.MEMread = 1'b1;
      bus.address = 32'd1032;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.MEMread = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("abort_ready", 32'(bus.ready), 32'd1);
      chk("abort_wb_en", 32'(sram_wb_en), 32'd1);
      chk("abort_result", bus.MEM_Result, 32'h0);
      repeat (8) @(posedge clk);
      #1;
      xact(1'b0, 1'b1, 32'd1024, 32'h0);
      chk("post_rst_read", bus.MEM_Result, 32'hDEADBEEF);
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Bridges the ARM pipeline MEM stage to an external 32-bit-wide asynchronous SRAM (17-bit word address, active-low controls).
- Converts a one-cycle-request style MEMread/MEMwrite into a multi-cycle SRAM access.
- Holds `ready` low until the access completes so the pipeline freezes.
- Read data is registered and presented on MEM_Result.

Parameters:
- WAIT_CYCLES, 5: SRAM access cycles per transaction; must cover the SRAM's 30 ns data-valid delay at the target clock.
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ADDR_W, 17: SRAM word-address width.

Ports:
- clk  input  1  controller/SRAM clock (sram_clk domain); all state changes on rising edge.
- rst  input  1  synchronous, active-low reset.
- MEMwrite  input  1  write request, held by the pipeline until ready=1.
- MEMread  input  1  read request, held until ready=1.
- address  input  32  byte address (ALU result).
- data  input  32  write data.
- MEM_Result  output  32  registered read data.
- ready  output  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- sram_dq  inout  32  SRAM data bus.
- sram_addr  output  17  SRAM word address.
- sram_wb_en  output  1  SRAM write enable, active low (SRAM_WE_N).
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0 (always enabled).

Behaviour:
- Address mapping, combinational: sram_addr = ((address - BASE_ADDR) >> 2) truncated to ADDR_W bits. The low two address bits are ignored; no range check; out-of-range addresses wrap modulo 2^17 words.
- State machine states: IDLE, ACCESS, DONE. A 3-bit counter cnt is used.
- Request definition: req = MEMread | MEMwrite. If both are asserted, the write takes priority.
- IDLE:
  - If req: next state ACCESS, cnt<=0.
  - ready = ~req, combinational, so it drops in the same cycle the request appears.
- ACCESS:
  - ready=0.
  - cnt increments each cycle.
  - When cnt==WAIT_CYCLES-1: next state DONE. If the access is a read, also MEM_Result<=sram_dq at that edge.
- DONE:
  - ready=1 for exactly one cycle; the pipeline advances at the end of this cycle.
  - Next state IDLE unconditionally, so a back-to-back request restarts from IDLE.
- Latency: request first seen in cycle 0; ready=1 in cycle WAIT_CYCLES+1 (cycle 6 by default); a new request is accepted the cycle after DONE.
- Write timing:
  - sram_wb_en=0 for all of ACCESS when the access is a write; 1 otherwise, including IDLE and DONE.
  - sram_dq driven with `data` only while sram_wb_en=0; otherwise high-Z.
  - The SRAM captures data on each ACCESS clock edge; the address is stable throughout.
- Read: sram_dq never driven by the controller; the SRAM drives it while sram_wb_en=1.
- MEM_Result holds its value until the next completed read. Writes do not change it.
- Reset (rst=0 at a rising edge): state IDLE, cnt 0, MEM_Result 0. This applies mid-access too; an aborted write may leave that SRAM word undefined.
  - Effective outputs after reset: sram_wb_en=1, sram_dq Z, ready=~req.
- Request dropped mid-access (protocol violation): the access still runs to DONE. A read completes normally; for a write, the `data` value being driven may change.

Decomposition:
- Shared package holds the state enum (IDLE/ACCESS/DONE), BASE_ADDR and the widths.
- Single module, no sub-module.
- The tri-state driver on sram_dq stays inline.

Test Plan:
- Reset: hold rst=0 for 2 cycles with no request → MEM_Result=0, ready=1, sram_wb_en=1, sram_dq Z.
- Single write: address=1024, data=0xDEADBEEF, MEMwrite=1 → ready=0 in cycles 0–5, ready=1 in cycle 6; sram_addr=0; sram_wb_en=0 in cycles 1–5; SRAM word 0 = 0xDEADBEEF.
- Read-back: write 0x12345678 to address 1032, then MEMread at 1032 → sram_addr=2; MEM_Result=0x12345678 with ready=1 in cycle 6.
- Back-to-back: write to 1028 then immediately read 1028 → the second transaction starts the cycle after DONE; read returns the written value; total 14 cycles.
- Address mapping: address=1024+4*300+3 → sram_addr=300 (low bits ignored).
- Reset mid-access: assert rst=0 at cnt=2 of a read → state IDLE, MEM_Result=0, sram_wb_en=1, no DONE pulse.
